// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file dump engine: state encoding,
// index width and default geometry of the architectural register file.
package regfile_dumper_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dumper.sv
// Freezes the core and streams every architectural register out as an
// (index, value) word on a valid/ready port, pulsing done after the last one.
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned NREGS   = NREGS_DEFAULT,
    parameter bit          SKIP_X0 = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_start,
    output logic                 io_busy,
    output logic                 io_stall_req,
    output logic [REG_IDX_W-1:0] io_rd_addr,
    input  logic [XLEN-1:0]      io_rd_data,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [REG_IDX_W-1:0] io_out_addr,
    output logic [XLEN-1:0]      io_out_data,
    output logic                 io_out_last,
    output logic                 io_done
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(NREGS - 1);
    localparam logic [REG_IDX_W-1:0] FIRST_IDX = SKIP_X0 ? REG_IDX_W'(1) : REG_IDX_W'(0);

    dump_state_e          state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]      out_data_q;
    logic [REG_IDX_W-1:0] out_addr_q;
    logic                 out_last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The index stops at the last register instead of wrapping, so the
    // read port keeps pointing at it through the DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (io_start) begin
                    idx_d   = FIRST_IDX;
                    state_d = READ;
                end
            end
            READ: state_d = SEND;
            SEND: begin
                if (io_out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + REG_IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_busy      = (state_q != IDLE);
        io_stall_req = (state_q != IDLE);
        io_out_valid = (state_q == SEND);
        io_done      = (state_q == DONE);
        io_rd_addr   = idx_q;
    end

    // The word is captured once in READ and held for the whole SEND phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q      <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            if (state_q == READ) begin
                out_data_q <= io_rd_data;
                out_addr_q <= idx_q;
                out_last_q <= (idx_q == LAST_IDX);
            end
        end
    end

    assign io_out_data = out_data_q;
    assign io_out_addr = out_addr_q;
    assign io_out_last = out_last_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: expected words are queued when a dump
// is requested and a negedge monitor pops them as the DUT hands words over.
module tb_regfile_dumper;
    import regfile_dumper_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clock;
    logic        reset;
    logic        start, ready;
    logic        busy, stall, valid, last, done;
    logic [4:0]  rdAddr, outAddr;
    logic [31:0] rdData, outData;

    logic        start2, ready2;
    logic        busy2, stall2, valid2, last2, done2;
    logic [4:0]  rdAddr2, outAddr2;
    logic [31:0] rdData2, outData2;

    logic [31:0] rf [32];
    word_t       q[$];
    word_t       q2[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acceptCount = 0;
    int doneCount = 0;
    int doneCount2 = 0;
    logic lastAccLast = 1'b0;
    logic lastAccLast2 = 1'b0;

    logic        holdValid = 1'b0;
    word_t       holdWord;

    assign rdData  = rf[rdAddr];
    assign rdData2 = rf[rdAddr2];

    regfile_dumper #(.XLEN(32), .NREGS(32), .SKIP_X0(1'b0)) dut (
        .clock(clock), .reset(reset), .io_start(start),
        .io_busy(busy), .io_stall_req(stall),
        .io_rd_addr(rdAddr), .io_rd_data(rdData),
        .io_out_valid(valid), .io_out_ready(ready),
        .io_out_addr(outAddr), .io_out_data(outData),
        .io_out_last(last), .io_done(done)
    );

    regfile_dumper #(.XLEN(32), .NREGS(32), .SKIP_X0(1'b1)) dutSkip (
        .clock(clock), .reset(reset), .io_start(start2),
        .io_busy(busy2), .io_stall_req(stall2),
        .io_rd_addr(rdAddr2), .io_rd_data(rdData2),
        .io_out_valid(valid2), .io_out_ready(ready2),
        .io_out_addr(outAddr2), .io_out_data(outData2),
        .io_out_last(last2), .io_done(done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] expVal(input int i, input bit patched);
        if (patched && i == 5) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Main monitor: pops on every handshake, checks holding under back-pressure.
    always @(negedge clock) begin
        word_t e;
        if (reset) begin
            holdValid = 1'b0;
        end else begin
            checkOutput("stall_eq_busy", 32'(stall), 32'(busy));
            if (valid) checkOutput("rd_addr_in_send", 32'(rdAddr), 32'(outAddr));
            if (holdValid) begin
                checkOutput("hold_valid", 32'(valid), 32'd1);
                checkOutput("hold_addr", 32'(outAddr), 32'(holdWord.addr));
                checkOutput("hold_data", outData, holdWord.data);
                checkOutput("hold_last", 32'(last), 32'(holdWord.last));
            end
            holdValid = 1'b0;
            if (valid && ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word: got addr %0d data 0x%08h, expected no word", outAddr, outData);
                end else begin
                    e = q.pop_front();
                    checkOutput("word_addr", 32'(outAddr), 32'(e.addr));
                    checkOutput("word_data", outData, e.data);
                    checkOutput("word_last", 32'(last), 32'(e.last));
                    lastAccLast = last;
                    acceptCount++;
                end
            end else if (valid) begin
                holdValid = 1'b1;
                holdWord  = '{addr: outAddr, data: outData, last: last};
            end
            if (done) begin
                doneCount++;
                checkOutput("done_queue_empty", 32'(q.size()), 32'd0);
                checkOutput("done_after_last", 32'(lastAccLast), 32'd1);
            end
        end
    end

    always @(negedge clock) begin
        word_t e;
        if (!reset) begin
            if (valid2 && ready2) begin
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL skip_unexpected_word: got addr %0d, expected no word", outAddr2);
                end else begin
                    e = q2.pop_front();
                    checkOutput("skip_word_addr", 32'(outAddr2), 32'(e.addr));
                    checkOutput("skip_word_data", outData2, e.data);
                    checkOutput("skip_word_last", 32'(last2), 32'(e.last));
                    lastAccLast2 = last2;
                end
            end
            if (done2) doneCount2++;
        end
    end

    task automatic applyStimulus(input bit skipDut, input bit patched);
        for (int i = (skipDut ? 1 : 0); i < 32; i++) begin
            if (skipDut) q2.push_back('{addr: 5'(i), data: expVal(i, patched), last: (i == 31)});
            else         q.push_back('{addr: 5'(i), data: expVal(i, patched), last: (i == 31)});
        end
        if (skipDut) start2 = 1'b1;
        else         start  = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // mode 0: ready high; 1: ready pattern 0,0,1; 2: stray start pulses
    task automatic runDump(input int mode, output int doneCyc);
        int base = acceptCount;
        int doneBefore = doneCount;
        int phase = 0;
        bit fired = 0;
        bit gotDone = 0;
        doneCyc = -1;
        for (int n = 0; n < 600; n++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (mode == 1) begin
                ready = (phase == 2);
                phase = (phase + 1) % 3;
                checkOutput("stall_during_dump", 32'(stall), 32'd1);
            end else begin
                ready = 1'b1;
            end
            if (mode == 2 && valid && (acceptCount - base) == 4 && !fired) begin
                start = 1'b1;
                fired = 1;
            end
            if (done) begin
                gotDone = 1;
                doneCyc = cyc;
                if (mode == 2) start = 1'b1;
                break;
            end
        end
        if (!gotDone) begin
            total++;
            bad++;
            $display("[TB] FAIL dump_timeout: got no done within 600 cycles, expected done");
        end
        @(posedge clock); #1;
        start = 1'b0;
        ready = 1'b1;
        checkOutput("idle_after_done", 32'(busy), 32'd0);
        if (mode == 2) checkOutput("stray_start_issued", 32'(fired), 32'd1);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("still_idle", 32'(busy), 32'd0);
        checkOutput("done_once", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("words_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 300000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startCyc, doneCyc;
        bit found;
        int doneBefore;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        reset = 1'b1; start = 1'b0; start2 = 1'b0; ready = 1'b1; ready2 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_out_addr", 32'(outAddr), 32'd0);
        checkOutput("rst_out_data", outData, 32'd0);
        checkOutput("rst_out_last", 32'(last), 32'd0);
        checkOutput("rst_rd_addr", 32'(rdAddr), 32'd0);

        $display("[TB] full dump, ready high");
        startCyc = cyc;
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1_valid", 32'(valid), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        @(posedge clock); #1;
        checkOutput("t2_valid", 32'(valid), 32'd1);
        checkOutput("t2_addr", 32'(outAddr), 32'd0);
        runDump(0, doneCyc);
        checkOutput("done_latency", 32'(doneCyc - startCyc), 32'd65);

        $display("[TB] SKIP_X0 dump");
        doneBefore = doneCount2;
        applyStimulus(1'b1, 1'b0);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock); #1;
            if (done2) begin found = 1; break; end
        end
        checkOutput("skip_done_seen", 32'(found), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("skip_done_once", 32'(doneCount2 - doneBefore), 32'd1);
        checkOutput("skip_drained", 32'(q2.size()), 32'd0);
        checkOutput("skip_last_seen", 32'(lastAccLast2), 32'd1);

        $display("[TB] back-pressure dump");
        applyStimulus(1'b0, 1'b0);
        runDump(1, doneCyc);

        $display("[TB] stray start pulses");
        applyStimulus(1'b0, 1'b0);
        runDump(2, doneCyc);

        $display("[TB] reset mid-dump");
        applyStimulus(1'b0, 1'b0);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock); #1;
            if (valid && outAddr == 5'd10) begin found = 1; break; end
        end
        checkOutput("reached_addr10", 32'(found), 32'd1);
        doneBefore = doneCount;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 32'(valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_stall", 32'(stall), 32'd0);
        checkOutput("mid_rst_out_addr", 32'(outAddr), 32'd0);
        checkOutput("mid_rst_out_data", outData, 32'd0);
        checkOutput("mid_rst_rd_addr", 32'(rdAddr), 32'd0);
        q.delete();
        repeat (70) @(posedge clock);
        #1;
        checkOutput("mid_rst_no_done", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("mid_rst_idle", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0);
        runDump(0, doneCyc);

        $display("[TB] rewrite x5 between dumps");
        rf[5] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b1);
        runDump(0, doneCyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
